// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, registered or FWFT read, threshold flags and sticky error flags.
// Define FIFO_FLEX_STATS_EN to add the peak_level and push_cnt statistics outputs.
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow,
`ifdef FIFO_FLEX_STATS_EN
    output logic [LW-1:0]         peak_level,
    output logic [31:0]           push_cnt,
`endif
    input  logic                  clr_err
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush masks both requests, so it also suppresses error events.
    assign push = wr_en && !full  && !flush;
    assign pop  = rd_en && !empty && !flush;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        level_d     = level_q;
        overflow_d  = (overflow_q  && !clr_err) || (wr_en && full  && !flush);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty && !flush);
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            level_d = '0;
        end else begin
            if (push) w_ptr_d = ptr_inc(w_ptr_q);
            if (pop)  r_ptr_d = ptr_inc(r_ptr_q);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[w_ptr_q] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = empty ? '0 : mem_q[r_ptr_q];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (pop) rdata_d = mem_q[r_ptr_q];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) rdata_q <= '0;
                else     rdata_q <= rdata_d;
            end

            assign rdata = rdata_q;
        end
    endgenerate

`ifdef FIFO_FLEX_STATS_EN
    logic [LW-1:0] peak_q, peak_d;
    logic [31:0]   push_cnt_q, push_cnt_d;

    // Peak tracks the post-edge level; flush leaves it untouched.
    always_comb begin
        peak_d     = (level_d > peak_q) ? level_d : peak_q;
        push_cnt_d = push_cnt_q;
        if (clr_err) peak_d = '0;
        if (push)    push_cnt_d = push_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q     <= '0;
            push_cnt_q <= '0;
        end else begin
            peak_q     <= peak_d;
            push_cnt_q <= push_cnt_d;
        end
    end

    assign peak_level = peak_q;
    assign push_cnt   = push_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Drives a registered-read and an FWFT fifo_flex (DEPTH=5) with shared stimulus against a queue model.
module tb_fifo_flex;

    localparam int DW = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic          full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [LW-1:0] level_a, level_b;

    always #5 clk = ~clk;

    fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_a), .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .level(level_a), .overflow(ovf_a), .underflow(udf_a), .clr_err(clr_err)
    );

    fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_b), .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .level(level_b), .overflow(ovf_b), .underflow(udf_b), .clr_err(clr_err)
    );

    // Reference model
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_reg;
    bit            m_ovf, m_udf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd_reg = '0;
        m_ovf    = 0;
        m_udf    = 0;
    endtask

    task automatic check_all();
        int lv;
        int head;
        lv   = mq.size();
        head = (lv == 0) ? 0 : int'(mq[0]);
        chk("reg.level",  int'(level_a), lv);
        chk("reg.full",   int'(full_a),  int'(lv == D));
        chk("reg.empty",  int'(empty_a), int'(lv == 0));
        chk("reg.af",     int'(af_a),    int'(lv >= AF));
        chk("reg.ae",     int'(ae_a),    int'(lv <= AE));
        chk("reg.ovf",    int'(ovf_a),   int'(m_ovf));
        chk("reg.udf",    int'(udf_a),   int'(m_udf));
        chk("reg.rdata",  int'(rdata_a), int'(m_rd_reg));
        chk("fwft.level", int'(level_b), lv);
        chk("fwft.full",  int'(full_b),  int'(lv == D));
        chk("fwft.empty", int'(empty_b), int'(lv == 0));
        chk("fwft.af",    int'(af_b),    int'(lv >= AF));
        chk("fwft.ae",    int'(ae_b),    int'(lv <= AE));
        chk("fwft.ovf",   int'(ovf_b),   int'(m_ovf));
        chk("fwft.udf",   int'(udf_b),   int'(m_udf));
        chk("fwft.rdata", int'(rdata_b), head);
    endtask

    // One clock: apply inputs, advance the model on the edge, then compare.
    task automatic cycle(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit fl, input bit ce);
        bit was_full, was_empty, ev_o, ev_u;
        wr_en   = wr;
        wdata   = wd;
        rd_en   = rd;
        flush   = fl;
        clr_err = ce;
        @(posedge clk);
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        ev_o = wr && was_full  && !fl;
        ev_u = rd && was_empty && !fl;
        m_ovf = (m_ovf && !ce) || ev_o;
        m_udf = (m_udf && !ce) || ev_u;
        if (fl) begin
            mq.delete();
        end else begin
            if (rd && !was_empty) m_rd_reg = mq.pop_front();
            if (wr && !was_full)  mq.push_back(wd);
        end
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Fill past full, then drain
        for (int i = 0; i < 6; i++) cycle(1, DW'(8'h11 + i), 0, 0, 0);
        chk("ovf_after_6th", int'(ovf_a), 1);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);

        // Pointer wrap: 3 in, then 1-in-1-out x9
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(1, DW'(8'h50 + i), 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0);

        // FWFT fall-through
        cycle(1, 8'hA5, 0, 0, 0);
        chk("fwft_a5", int'(rdata_b), 8'hA5);
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);

        // Flush with simultaneous requests, then underflow and clear
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'h60 + i), 0, 0, 0);
        cycle(1, 8'h99, 1, 1, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);

        // Randomized traffic, biased to sweep the whole level range
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 40) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(0, 99) < bias, DW'($urandom), $urandom_range(0, 99) >= bias,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
        end

        // Async reset between edges in the middle of a write burst
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'hC0 + i), 0, 0, 0);
        wr_en = 1'b1;
        wdata = 8'hCF;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 8'h77, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        chk("post_reset_data", int'(rdata_a), 8'h77);
        cycle(0, '0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
